byte_accumulator: RTL and testbench
===================================

# byte_accumulator

Sequential front-end stage that collects a stream of 8-bit operands over a valid/ready handshake and sums them into a 16-bit result. It uses one 8-bit add datapath, the same width as the team's `adder8` ripple adder, and splits each 16-bit addition into a low-byte cycle and a high-byte cycle with a registered carry. After `COUNT` operands it presents the total and a sticky overflow flag on an output handshake. It sits between a byte source (UART receiver, switches, test pattern generator) and the result consumer (display or transmitter).

## Interface
- `COUNT`, default 4: operands per batch; legal range 1..1023.
- `clk` input 1: single clock, all state updates on rising edge.
- `reset_n` input 1: synchronous, active-low reset.
- `in_data` input 8: operand, unsigned.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: block can accept an operand this cycle.
- `clear` input 1: synchronous batch abort.
- `sum` output 16: running or final total, unsigned, modulo 65536.
- `overflow` output 1: sticky; some add in the batch carried out of bit 15.
- `sum_valid` output 1: `sum`/`overflow` hold the final batch result.
- `sum_ready` input 1: consumer accepts the result.

## Operation
- State machine states are IDLE, LO, HI and DONE.
- Internal registers:
  - `acc[15:0]`
  - `opnd[7:0]`
  - `carry` (1 bit)
  - `cnt[9:0]`
  - `ovf`
- `sum` = `acc` and `overflow` = `ovf` at all times. Intermediate values are visible but meaningful only while `sum_valid` is high.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid && in_ready`: `opnd` <= `in_data`, go to LO.
  - Otherwise stay in IDLE.
- LO:
  - `{carry, acc[7:0]}` <= `acc[7:0] + opnd` (9-bit result).
  - Go to HI.
- HI:
  - `{c16, acc[15:8]}` <= `acc[15:8] + 8'h00 + carry`.
  - `ovf` <= `ovf | c16`.
  - `cnt` <= `cnt + 1`.
  - If `cnt + 1 == COUNT`, go to DONE; else go to IDLE.
- DONE:
  - `sum_valid` = 1 and `in_ready` = 0.
  - `acc` and `ovf` are frozen.
  - On `sum_valid && sum_ready`: `acc` <= 0, `ovf` <= 0, `cnt` <= 0, go to IDLE.
- `in_ready` is 0 in LO, HI and DONE. `in_data` is ignored in those states even when `in_valid` is high.
- `clear` (when `reset_n` is high) has priority over all handshakes in any state:
  - `acc`, `cnt`, `carry` and `ovf` <= 0.
  - State <= IDLE.
  - An operand being accepted that same cycle is discarded.
  - In DONE, the result is dropped without a transfer.
- `reset_n` = 0 has priority over `clear`. It has the same effect as `clear` and also zeroes `opnd`.
- Width rules:
  - Operands are zero-extended.
  - The sum wraps modulo 2^16.
  - `ovf` sets on any wrap and stays set until transfer, `clear` or reset.
  - Maximum exact sum without wrap is 257 × 255 = 65535.

## Timing
- Reset values:
  - `in_ready` = 1 (state IDLE).
  - `sum_valid` = 0.
  - `sum` = 16'h0000.
  - `overflow` = 0.
- Per operand: accept cycle (IDLE) → LO → HI. Minimum 3 cycles per operand, so throughput is at most one operand every 3 cycles.
- With `in_valid` held high, operand k (0-based) is accepted in cycle 3k, counting from the first accept cycle = 0.
- `sum_valid` rises in cycle 3·COUNT. It is registered, with no combinational path from any input.
- DONE holds `sum`, `overflow` and `sum_valid` stable for any number of cycles while `sum_ready` = 0.
- After the transfer cycle, the next cycle is IDLE with `in_ready` = 1 and `sum` = 0. There is no bubble beyond this cycle.
- `sum_ready` is ignored outside DONE.
- `COUNT` = 1: the HI cycle goes straight to DONE.

## Test plan
- Basic sum: `COUNT` = 4; feed 0x10, 0x20, 0x30, 0x40 with `in_valid` held high.
  - Required: `sum_valid` = 1 in cycle 12 after the first accept.
  - Required: `sum` = 0x00A0, `overflow` = 0.
  - Required: `in_ready` pattern is 1,0,0 repeating.
- Carry propagation: `COUNT` = 2; feed 0xFF, 0xFF.
  - Required: after operand 1, `sum` = 0x00FF.
  - Required: final `sum` = 0x01FE, `overflow` = 0.
  - Check: the HI-cycle carry is visible in `acc[8]`.
- Overflow wrap: `COUNT` = 258; feed 0xFF every accept.
  - Required: `sum` = 0x00FE, `overflow` = 1.
  - Check: `overflow` first rises in the HI cycle of operand 257.
  - Required: both outputs stay stable until transfer.
- Handshake backpressure:
  - Hold `sum_ready` = 0 for 5 cycles in DONE while `in_valid` = 1 and `in_data` is toggling. Required: `sum` is unchanged and `in_ready` = 0 throughout.
  - Raise `sum_ready` for one cycle. Required: next cycle `sum_valid` = 0, `sum` = 0, `in_ready` = 1.
  - Next batch with `COUNT` = 4 and inputs 1, 2, 3, 4. Required: `sum` = 0x000A.
- Abort and reset: `COUNT` = 4.
  - Assert `clear` during the LO cycle of operand 2, then feed 5, 5, 5, 5. Required: `sum` = 0x0014.
  - Repeat with `reset_n` = 0 in DONE while `sum_ready` = 1. Required: no transfer counted, and next cycle all outputs equal their reset values.

Source files
------------

// File: rtl/byte_accumulator.sv
// byte_accumulator: sums COUNT unsigned bytes into a 16-bit total using one
// 8-bit add per cycle. Each operand takes a low-byte add, then a high-byte add
// with the carry held in a register. A sticky flag records any wrap past 16 bits.
module byte_accumulator #(
  parameter int COUNT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        clear,
  output logic [15:0] sum,
  output logic        overflow,
  output logic        sum_valid,
  input  logic        sum_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  // cnt holds the number of finished operands, so the last HI cycle sees COUNT-1
  localparam logic [9:0] LastCnt = 10'(COUNT - 1);

  state_t      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [7:0]  opnd_q, opnd_d;
  logic        carry_q, carry_d;
  logic [9:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic        c16;

  // State register: reset returns to IDLE, otherwise follow the next-state logic
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: clear aborts from any state, otherwise walk accept/LO/HI
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) state_d = LO;
        LO:   state_d = HI;
        HI:   state_d = (cnt_q == LastCnt) ? DONE : IDLE;
        DONE: if (sum_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs decode the state register only, so nothing here depends on an input
  always_comb begin
    in_ready  = (state_q == IDLE);
    sum_valid = (state_q == DONE);
    sum       = acc_q;
    overflow  = ovf_q;
  end

  // Datapath next-state: one 8-bit add per cycle, low byte first, then high byte plus carry
  always_comb begin
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    c16     = 1'b0;
    if (clear) begin
      acc_d   = 16'h0000;
      carry_d = 1'b0;
      cnt_d   = 10'd0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) opnd_d = in_data;
        end
        LO: begin
          {carry_d, acc_d[7:0]} = {1'b0, acc_q[7:0]} + {1'b0, opnd_q};
        end
        HI: begin
          {c16, acc_d[15:8]} = {1'b0, acc_q[15:8]} + {8'h00, carry_q};
          ovf_d = ovf_q | c16;
          cnt_d = cnt_q + 10'd1;
        end
        DONE: begin
          if (sum_ready) begin
            acc_d = 16'h0000;
            ovf_d = 1'b0;
            cnt_d = 10'd0;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers: reset also clears the held operand
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q   <= 16'h0000;
      opnd_q  <= 8'h00;
      carry_q <= 1'b0;
      cnt_q   <= 10'd0;
      ovf_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_byte_accumulator.sv
// Bench for byte_accumulator: three instances (COUNT = 4, 2, 258) share one clock.
// The expected result of a batch is the plain integer sum of the bytes fed in,
// taken modulo 65536, with overflow meaning that integer sum exceeded 65535.
module tb_byte_accumulator;

  logic        clk = 1'b0;
  logic        resetN[3];
  logic        clear[3];
  logic [7:0]  inData[3];
  logic        inValid[3];
  logic        inReady[3];
  logic [15:0] sum[3];
  logic        overflow[3];
  logic        sumValid[3];
  logic        sumReady[3];

  int expTotal[3];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  byte_accumulator #(.COUNT(4)) dut0 (
    .clk(clk), .reset_n(resetN[0]), .in_data(inData[0]), .in_valid(inValid[0]),
    .in_ready(inReady[0]), .clear(clear[0]), .sum(sum[0]), .overflow(overflow[0]),
    .sum_valid(sumValid[0]), .sum_ready(sumReady[0])
  );

  byte_accumulator #(.COUNT(2)) dut1 (
    .clk(clk), .reset_n(resetN[1]), .in_data(inData[1]), .in_valid(inValid[1]),
    .in_ready(inReady[1]), .clear(clear[1]), .sum(sum[1]), .overflow(overflow[1]),
    .sum_valid(sumValid[1]), .sum_ready(sumReady[1])
  );

  byte_accumulator #(.COUNT(258)) dut2 (
    .clk(clk), .reset_n(resetN[2]), .in_data(inData[2]), .in_valid(inValid[2]),
    .in_ready(inReady[2]), .clear(clear[2]), .sum(sum[2]), .overflow(overflow[2]),
    .sum_valid(sumValid[2]), .sum_ready(sumReady[2])
  );

  // Single comparison point: count it and report any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Checks all outputs of one instance against their reset values
  task automatic checkResetValues(input int d, input string tag);
    checkOutput({tag, "_inReady"}, 32'(inReady[d]), 32'd1);
    checkOutput({tag, "_sumValid"}, 32'(sumValid[d]), 32'd0);
    checkOutput({tag, "_sum"}, 32'(sum[d]), 32'd0);
    checkOutput({tag, "_overflow"}, 32'(overflow[d]), 32'd0);
  endtask

  // Offers one operand when the block is ready; called and returning at a negedge
  task automatic applyStimulus(input int d, input logic [7:0] data);
    int waited = 0;
    while (!inReady[d] && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("acceptReady", 32'(inReady[d]), 32'd1);
    inValid[d] = 1'b1;
    inData[d]  = data;
    expTotal[d] += int'(data);
    @(negedge clk);
    inValid[d] = 1'b0;
    inData[d]  = 8'($urandom);
  endtask

  // Waits until the current operand has been fully added
  task automatic waitSettle(input int d);
    int waited = 0;
    while (!(inReady[d] || sumValid[d]) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("settle", 32'(inReady[d] | sumValid[d]), 32'd1);
  endtask

  // Waits for the result, checks it against the model, holds it off, then takes it
  task automatic finishBatch(input int d, input int hold, input string tag);
    int waited = 0;
    logic [15:0] expSum;
    logic        expOvf;
    expSum = 16'(expTotal[d] % 65536);
    expOvf = (expTotal[d] > 65535);
    while (!sumValid[d] && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    checkOutput({tag, "_valid"}, 32'(sumValid[d]), 32'd1);
    checkOutput({tag, "_sum"}, 32'(sum[d]), 32'(expSum));
    checkOutput({tag, "_ovf"}, 32'(overflow[d]), 32'(expOvf));
    sumReady[d] = 1'b0;
    for (int i = 0; i < hold; i++) begin
      inValid[d] = 1'b1;
      inData[d]  = 8'($urandom);
      @(negedge clk);
      checkOutput({tag, "_holdSum"}, 32'(sum[d]), 32'(expSum));
      checkOutput({tag, "_holdOvf"}, 32'(overflow[d]), 32'(expOvf));
      checkOutput({tag, "_holdValid"}, 32'(sumValid[d]), 32'd1);
      checkOutput({tag, "_holdRdy"}, 32'(inReady[d]), 32'd0);
    end
    sumReady[d] = 1'b1;
    @(negedge clk);
    sumReady[d] = 1'b0;
    inValid[d]  = 1'b0;
    expTotal[d] = 0;
    checkOutput({tag, "_postValid"}, 32'(sumValid[d]), 32'd0);
    checkOutput({tag, "_postSum"}, 32'(sum[d]), 32'd0);
    checkOutput({tag, "_postRdy"}, 32'(inReady[d]), 32'd1);
  endtask

  initial begin
    logic [7:0] ops[4];
    logic [7:0] fives;
    int waited;

    for (int d = 0; d < 3; d++) begin
      resetN[d] = 1'b0; clear[d] = 1'b0; inData[d] = 8'h00;
      inValid[d] = 1'b0; sumReady[d] = 1'b0; expTotal[d] = 0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) resetN[d] = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) checkResetValues(d, $sformatf("reset%0d", d));

    // Basic sum with in_valid held high: cycle-exact ready/valid pattern
    ops[0] = 8'h10; ops[1] = 8'h20; ops[2] = 8'h30; ops[3] = 8'h40;
    inValid[0] = 1'b1;
    for (int n = 0; n <= 12; n++) begin
      if (n > 0) @(negedge clk);
      checkOutput($sformatf("basicRdy%0d", n), 32'(inReady[0]), 32'((n < 12) && (n % 3 == 0)));
      checkOutput($sformatf("basicVld%0d", n), 32'(sumValid[0]), 32'(n == 12));
      if (n < 12 && n % 3 == 0) begin
        inData[0] = ops[n / 3];
        expTotal[0] += int'(ops[n / 3]);
      end else begin
        inData[0] = 8'($urandom);
      end
    end
    finishBatch(0, 5, "basic");

    // Next batch right after the transfer
    for (int i = 1; i <= 4; i++) applyStimulus(0, 8'(i));
    finishBatch(0, 0, "oneToFour");

    // Carry propagation into the high byte
    applyStimulus(1, 8'hFF);
    waitSettle(1);
    checkOutput("carryFirst", 32'(sum[1]), 32'h00FF);
    applyStimulus(1, 8'hFF);
    finishBatch(1, 2, "carry");

    // Overflow wrap: 257 x 0xFF is the largest exact sum, one more wraps
    for (int i = 0; i < 257; i++) begin
      applyStimulus(2, 8'hFF);
      waitSettle(2);
    end
    checkOutput("wrapPreSum", 32'(sum[2]), 32'hFFFF);
    checkOutput("wrapPreOvf", 32'(overflow[2]), 32'd0);
    applyStimulus(2, 8'hFF);
    finishBatch(2, 4, "wrap");

    // Clear during the LO cycle of the third operand
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 8'($urandom));
      if (i < 2) waitSettle(0);
    end
    clear[0] = 1'b1;
    @(negedge clk);
    clear[0] = 1'b0;
    expTotal[0] = 0;
    checkOutput("clearSum", 32'(sum[0]), 32'd0);
    checkOutput("clearRdy", 32'(inReady[0]), 32'd1);
    fives = 8'h05;
    for (int i = 0; i < 4; i++) applyStimulus(0, fives);
    finishBatch(0, 1, "afterClear");

    // Reset in DONE while sum_ready is high
    for (int i = 0; i < 4; i++) applyStimulus(0, 8'($urandom_range(1, 255)));
    waited = 0;
    while (!sumValid[0] && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("rstDoneValid", 32'(sumValid[0]), 32'd1);
    sumReady[0] = 1'b1;
    resetN[0] = 1'b0;
    @(negedge clk);
    resetN[0] = 1'b1;
    sumReady[0] = 1'b0;
    expTotal[0] = 0;
    checkResetValues(0, "rstDone");

    // Randomized batches with random idle gaps on the short instances
    for (int b = 0; b < 4; b++) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < (d == 0 ? 4 : 2); i++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          applyStimulus(d, 8'($urandom));
        end
        finishBatch(d, int'($urandom_range(0, 3)), $sformatf("rand%0d_%0d", b, d));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
